// File: rtl/reg_file_mp_pkg.sv
// Shared types and defaults for the multi-read-port register file.
package reg_file_mp_pkg;

  // Clear engine states: sweeping the array, or serving reads and writes.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int NUM_RD_DEF = 2;

  // Number of entries addressable with addr_w bits.
  function automatic int calc_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: entry select, hardwired-zero entry,
// write-through bypass and the ready gate, in that priority order.
module reg_file_rd_port
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1,
  parameter int DEPTH    = calc_depth(ADDR_W)
) (
  input  logic                         i_ready,
  input  logic [ADDR_W-1:0]            i_rd_addr,
  input  logic                         i_wr_accept,
  input  logic [ADDR_W-1:0]            i_wr_addr,
  input  logic [DATA_W-1:0]            i_wr_data,
  input  logic [DEPTH-1:0][DATA_W-1:0] i_mem,
  output logic [DATA_W-1:0]            o_rd_data
);

  logic w_is_zero_reg;
  logic w_bypass_hit;

  assign w_is_zero_reg = ZERO_REG && (i_rd_addr == '0);
  assign w_bypass_hit  = BYPASS && i_wr_accept && (i_rd_addr == i_wr_addr);

  // Resolve the read value; an unready file never exposes stale contents.
  always_comb begin
    // NOTE: assign a default first so every path drives the output and no latch is inferred.
    o_rd_data = '0;
    if (!i_ready) begin
      o_rd_data = '0;
    end else if (w_is_zero_reg) begin
      o_rd_data = '0;
    end else if (w_bypass_hit) begin
      o_rd_data = i_wr_data;
    end else begin
      o_rd_data = i_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file with NUM_RD combinational read ports, one
// write port, optional hardwired-zero entry 0, optional write-through
// bypass, and a clear engine that zeroes every entry after reset or on
// request before the file reports ready.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clear_req,
  output logic                     ready,
  output logic                     wr_drop
);

  localparam int                DEPTH    = calc_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  state_e                       r_state;
  logic [ADDR_W-1:0]            r_clr_cnt;
  logic                         r_wr_drop;

  logic w_ready;
  logic w_wr_accept;
  logic w_wr_store;

  assign w_ready     = (r_state == ST_READY);
  assign w_wr_accept = w_ready && wr_en;
  // Writes to a hardwired-zero entry are accepted but silently discarded.
  assign w_wr_store  = w_wr_accept && !(ZERO_REG && (wr_addr == '0));

  // Clear FSM and rejected-write flag; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= wr_en && !w_ready;
      case (r_state)
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == LAST_IDX) begin
            r_state <= ST_READY;
          end
        end
        ST_READY: begin
          if (clear_req) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
          end
        end
        default: begin
          r_state   <= ST_CLEAR;
          r_clr_cnt <= '0;
        end
      endcase
    end
  end

  // Storage: the sweep zeroes one entry per edge, otherwise accepted writes land.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; the clear engine zeroes it, keeping it a plain RAM.
    if (!reset) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_clr_cnt] <= '0;
      end else if (w_wr_store) begin
        r_mem[wr_addr] <= wr_data;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      reg_file_rd_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS),
        .DEPTH   (DEPTH)
      ) u_rd_port (
        .i_ready    (w_ready),
        .i_rd_addr  (rd_addr[g*ADDR_W +: ADDR_W]),
        .i_wr_accept(w_wr_accept),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_mem      (r_mem),
        .o_rd_data  (rd_data[g*DATA_W +: DATA_W])
      );
    end
  endgenerate

  assign ready   = w_ready;
  assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three configurations driven from one stimulus
// stream (default, ZERO_REG=1/BYPASS=0, and 4 ports x 32 bits x 32 entries),
// each compared every cycle against an entry-level behavioural model.
module tb_reg_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus; narrower instances take the low bits.
  logic        s_reset;
  logic        s_wr_en;
  logic        s_clear;
  logic [4:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic [4:0]  s_rd_addr [4];

  logic [15:0]  a_rd_data, b_rd_data;
  logic [127:0] c_rd_data;
  logic         a_ready, b_ready, c_ready;
  logic         a_drop, b_drop, c_drop;

  int n_checks = 0;
  int n_errors = 0;

  reg_file_mp dut_a (
    .clk(clk), .reset(s_reset),
    .rd_addr({s_rd_addr[1][3:0], s_rd_addr[0][3:0]}), .rd_data(a_rd_data),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr[3:0]), .wr_data(s_wr_data[7:0]),
    .clear_req(s_clear), .ready(a_ready), .wr_drop(a_drop)
  );

  reg_file_mp #(.ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
    .clk(clk), .reset(s_reset),
    .rd_addr({s_rd_addr[1][3:0], s_rd_addr[0][3:0]}), .rd_data(b_rd_data),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr[3:0]), .wr_data(s_wr_data[7:0]),
    .clear_req(s_clear), .ready(b_ready), .wr_drop(b_drop)
  );

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) dut_c (
    .clk(clk), .reset(s_reset),
    .rd_addr({s_rd_addr[3], s_rd_addr[2], s_rd_addr[1], s_rd_addr[0]}), .rd_data(c_rd_data),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .clear_req(s_clear), .ready(c_ready), .wr_drop(c_drop)
  );

  // ---------------- behavioural model ----------------
  // Per instance: entry contents, edges left until ready (0 = ready), drop flag.
  logic [31:0] m_mem  [3][32];
  int          m_left [3];
  logic        m_drop [3];

  function automatic int inst_aw(input int k);   return (k == 2) ? 5 : 4; endfunction
  function automatic int inst_nrd(input int k);  return (k == 2) ? 4 : 2; endfunction
  function automatic bit inst_zr(input int k);   return (k == 1); endfunction
  function automatic bit inst_byp(input int k);  return (k != 1); endfunction

  function automatic int cut_addr(input int k, input logic [4:0] a);
    return int'(a) % (1 << inst_aw(k));
  endfunction

  function automatic logic [31:0] cut_data(input int k, input logic [31:0] d);
    return (k == 2) ? d : {24'h0, d[7:0]};
  endfunction

  function automatic logic [31:0] exp_rd(input int k, input int p);
    int a;
    a = cut_addr(k, s_rd_addr[p]);
    if (m_left[k] != 0) return 32'h0;
    if (inst_zr(k) && a == 0) return 32'h0;
    if (inst_byp(k) && s_wr_en && a == cut_addr(k, s_wr_addr)) return cut_data(k, s_wr_data);
    return m_mem[k][a];
  endfunction

  function automatic logic [31:0] act_rd(input int k, input int p);
    case (k)
      0:       return {24'h0, a_rd_data[p*8 +: 8]};
      1:       return {24'h0, b_rd_data[p*8 +: 8]};
      default: return c_rd_data[p*32 +: 32];
    endcase
  endfunction

  function automatic logic act_ready(input int k);
    return (k == 0) ? a_ready : (k == 1) ? b_ready : c_ready;
  endfunction

  function automatic logic act_drop(input int k);
    return (k == 0) ? a_drop : (k == 1) ? b_drop : c_drop;
  endfunction

  task automatic model_zero(input int k);
    for (int i = 0; i < 32; i++) m_mem[k][i] = 32'h0;
  endtask

  // Advance the model by one rising edge using the inputs held across it.
  // Entries are zeroed as soon as a sweep starts: nothing can observe them
  // until the sweep ends, when all of them read zero.
  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      int depth, wa;
      depth = 1 << inst_aw(k);
      wa    = cut_addr(k, s_wr_addr);
      if (s_reset) begin
        m_left[k] = depth;
        m_drop[k] = 1'b0;
        model_zero(k);
      end else if (m_left[k] > 0) begin
        m_drop[k] = s_wr_en;
        m_left[k] = m_left[k] - 1;
      end else begin
        m_drop[k] = 1'b0;
        if (s_wr_en && !(inst_zr(k) && wa == 0)) m_mem[k][wa] = cut_data(k, s_wr_data);
        if (s_clear) begin
          m_left[k] = depth;
          model_zero(k);
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ready[%0d]", k), {31'h0, act_ready(k)}, {31'h0, m_left[k] == 0});
      check($sformatf("wr_drop[%0d]", k), {31'h0, act_drop(k)}, {31'h0, m_drop[k]});
      for (int p = 0; p < inst_nrd(k); p++)
        check($sformatf("rd_data[%0d][%0d]", k, p), act_rd(k, p), exp_rd(k, p));
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    edge_step();
  endtask

  // Run up to 40 edges and record after which edge each instance went ready.
  task automatic measure_rise(input string tag, input int exp_narrow, input int exp_wide);
    int rise [3];
    rise = '{-1, -1, -1};
    for (int n = 1; n <= 40; n++) begin
      for (int p = 0; p < 4; p++) s_rd_addr[p] = 5'($urandom);
      tick();
      for (int k = 0; k < 3; k++)
        if (rise[k] < 0 && act_ready(k) === 1'b1) rise[k] = n;
    end
    check({tag, "_rise_a"}, rise[0], exp_narrow);
    check({tag, "_rise_b"}, rise[1], exp_narrow);
    check({tag, "_rise_c"}, rise[2], exp_wide);
  endtask

  // Every entry of the default instance reads zero on both ports.
  task automatic sweep_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      for (int p = 0; p < 4; p++) s_rd_addr[p] = 5'(a);
      #1;
      if (a < 16) begin
        check($sformatf("%s_a_p0_%0d", tag, a), act_rd(0, 0), 32'h0);
        check($sformatf("%s_a_p1_%0d", tag, a), act_rd(0, 1), 32'h0);
      end
      check($sformatf("%s_c_p3_%0d", tag, a), act_rd(2, 3), 32'h0);
      tick();
    end
  endtask

  typedef struct {
    logic       we;
    logic [4:0] wa;
    logic [7:0] wd;
    logic [4:0] r0, r1;
    logic [7:0] a0, a1;  // expected default instance
    logic [7:0] b0, b1;  // expected ZERO_REG=1, BYPASS=0 instance
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_left[k] = 99;
      m_drop[k] = 1'b0;
      model_zero(k);
    end
    s_reset = 1'b1; s_wr_en = 1'b0; s_clear = 1'b0;
    s_wr_addr = '0; s_wr_data = '0;
    for (int p = 0; p < 4; p++) s_rd_addr[p] = '0;

    // Reset for two edges, then observe the power-up sweep.
    edge_step();
    edge_step();
    tick();
    s_reset = 1'b0;
    measure_rise("reset", 16, 32);
    sweep_zero("post_reset");

    // Directed write/read, bypass and zero-register vectors.
    vecs[0] = '{1'b1, 5'd3,  8'hA5, 5'd3,  5'd3,  8'hA5, 8'hA5, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 5'd0,  8'h00, 5'd3,  5'd3,  8'hA5, 8'hA5, 8'hA5, 8'hA5};
    vecs[2] = '{1'b1, 5'd15, 8'h3C, 5'd15, 5'd3,  8'h3C, 8'hA5, 8'h00, 8'hA5};
    vecs[3] = '{1'b0, 5'd0,  8'h00, 5'd15, 5'd15, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
    vecs[4] = '{1'b1, 5'd5,  8'h77, 5'd3,  5'd5,  8'hA5, 8'h77, 8'hA5, 8'h00};
    vecs[5] = '{1'b1, 5'd0,  8'hFF, 5'd0,  5'd5,  8'hFF, 8'h77, 8'h00, 8'h77};
    vecs[6] = '{1'b1, 5'd1,  8'hFF, 5'd0,  5'd1,  8'hFF, 8'hFF, 8'h00, 8'h00};
    vecs[7] = '{1'b0, 5'd0,  8'h00, 5'd0,  5'd1,  8'hFF, 8'hFF, 8'h00, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      s_wr_en = vecs[i].we; s_wr_addr = vecs[i].wa; s_wr_data = {24'h0, vecs[i].wd};
      s_rd_addr[0] = vecs[i].r0; s_rd_addr[1] = vecs[i].r1;
      s_rd_addr[2] = vecs[i].r1; s_rd_addr[3] = vecs[i].r0;
      @(negedge clk);
      check($sformatf("vec%0d_a_p0", i), act_rd(0, 0), {24'h0, vecs[i].a0});
      check($sformatf("vec%0d_a_p1", i), act_rd(0, 1), {24'h0, vecs[i].a1});
      check($sformatf("vec%0d_b_p0", i), act_rd(1, 0), {24'h0, vecs[i].b0});
      check($sformatf("vec%0d_b_p1", i), act_rd(1, 1), {24'h0, vecs[i].b1});
      check($sformatf("vec%0d_b_drop", i), {31'h0, b_drop}, 32'h0);
      check_model();
      edge_step();
    end
    s_wr_en = 1'b0;

    // Fill with nonzero data, then request a clear.
    for (int a = 0; a < 32; a++) begin
      s_wr_en = 1'b1; s_wr_addr = 5'(a); s_wr_data = $urandom | 32'h1;
      tick();
    end
    s_wr_en = 1'b0;
    s_clear = 1'b1;
    tick();
    s_clear = 1'b0;
    check("clr_ready_low", {31'h0, a_ready}, 32'h0);
    begin
      int rise_a, rise_c;
      rise_a = -1; rise_c = -1;
      for (int n = 1; n <= 40; n++) begin
        s_wr_en = (n == 3); s_wr_addr = 5'd4; s_wr_data = 32'h5A5A_5A5A;
        s_clear = (n == 5);  // ignored mid-sweep
        tick();
        if (n == 3) check("sweep_drop_pulse", {31'h0, a_drop}, 32'h1);
        if (n == 4) check("sweep_drop_width", {31'h0, a_drop}, 32'h0);
        if (rise_a < 0 && a_ready === 1'b1) rise_a = n;
        if (rise_c < 0 && c_ready === 1'b1) rise_c = n;
      end
      s_wr_en = 1'b0; s_clear = 1'b0;
      check("clr_rise_a", rise_a, 16);
      check("clr_rise_c", rise_c, 32);
    end
    sweep_zero("post_clear");

    // Reset asserted when the sweep reaches entry 7 restarts it.
    s_clear = 1'b1;
    tick();
    s_clear = 1'b0;
    for (int n = 0; n < 7; n++) tick();
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
    measure_rise("mid_reset", 16, 32);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      s_reset   = ($urandom_range(599) == 0);
      s_clear   = ($urandom_range(79) == 0);
      s_wr_en   = ($urandom_range(3) != 0);
      s_wr_addr = 5'($urandom);
      s_wr_data = $urandom;
      for (int p = 0; p < 4; p++)
        s_rd_addr[p] = ($urandom_range(3) == 0) ? s_wr_addr : 5'($urandom);
      tick();
    end
    s_reset = 1'b0; s_clear = 1'b0; s_wr_en = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file, successor to the fixed 16x8 two-read-port file. It feeds ALU operands from NUM_RD combinational read ports and takes one write port from the ALU result path. It adds an optional hardwired-zero entry 0 and optional write-through bypass. It also has a sequential clear engine that sweeps every entry to zero after reset or on request, and reports readiness.

## Interface
- DATA_W, 8, entry width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..8)
- ZERO_REG, 0, 1: entry 0 always reads 0 and writes to it are discarded
- BYPASS, 1, 1: a read of the address being written in the same cycle returns wr_data

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W]
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- clear_req  in  1  single-cycle request to re-zero the whole file
- ready  out  1  high when the file accepts writes and returns stored data
- wr_drop  out  1  registered pulse: a write was rejected in the previous cycle

## Operation
- FSM states:
  - ST_CLEAR: sweeping; clr_cnt (ADDR_W bits) selects the entry to zero.
  - ST_READY: normal operation.
- Reset high at an edge: state becomes ST_CLEAR, clr_cnt becomes 0, wr_drop becomes 0. Array contents are not touched by reset itself.
- ST_CLEAR, each edge with reset low:
  - entry[clr_cnt] is set to 0 and clr_cnt increments.
  - Once entry DEPTH-1 is cleared, the state becomes ST_READY.
  - clr_cnt wraps to 0.
- ST_READY, clear_req high: state becomes ST_CLEAR with clr_cnt = 0. A write in that same cycle is still performed, then overwritten by the sweep.
- A write is accepted only when ready=1 and wr_en=1.
  - Entry wr_addr takes wr_data at the edge.
  - If ZERO_REG=1 and wr_addr=0, the write is discarded silently; wr_drop stays 0.
- wr_en=1 while ready=0: the write is ignored and wr_drop is 1 for the following cycle.
- clear_req while in ST_CLEAR is ignored; the sweep does not restart.
- Reads are combinational, evaluated independently per port, in priority order:
  1. ready=0 gives 0.
  2. ZERO_REG=1 and addr=0 gives 0.
  3. BYPASS=1, accepted write, and addr=wr_addr gives wr_data.
  4. Otherwise entry[addr].
- Any number of ports may read the same address. All ports see identical results.

## Timing
- Reset values: ready=0, wr_drop=0, rd_data=0 on every port.
- Clear time: ready rises DEPTH edges after the first edge with reset low (16 for the default). It stays low for the whole sweep.
- clear_req: ready drops 0 cycles later in registered terms, i.e. the edge that samples clear_req. It returns DEPTH edges after that.
- Read latency 0: rd_data follows rd_addr in the same cycle. A written value is visible without bypass from the cycle after the write edge.
- wr_drop latency is 1 cycle and its width is 1 cycle per rejected write.
- Reset asserted mid-sweep restarts the sweep from clr_cnt=0.

## Structure
- Package reg_file_mp_pkg holds:
  - the state enum (ST_CLEAR, ST_READY)
  - default parameter constants (DATA_W_DEF=8, ADDR_W_DEF=4, NUM_RD_DEF=2)
  - the function computing DEPTH from ADDR_W
- Sub-module reg_file_rd_port holds one read port: the address mux, the zero-register check, bypass compare and the ready gate. The top instantiates it NUM_RD times in a generate loop.
- The top holds the storage array, write logic, clear FSM and wr_drop.

## Test plan
- Reset for 2 cycles, release: ready=0 and all rd_data=0 for 16 edges, ready=1 at the 16th; all 16 entries read 0.
- Sequential write/read, defaults:
  - write 0xA5 to addr 3, then read port0 addr 3 and port1 addr 3 next cycle -> both 0xA5.
  - write 0x3C to addr 15 -> read 0x3C.
- Bypass, BYPASS=1: write 0x77 to addr 5 while port1 reads addr 5 in the same cycle -> rd_data port1 = 0x77 that cycle. With BYPASS=0 it shows the old value 0x00.
- Zero register, ZERO_REG=1: write 0xFF to addr 0 -> reads of addr 0 return 0x00 and wr_drop stays 0. Write 0xFF to addr 1 reads 0xFF.
- Clear request:
  - after filling entries with nonzero data, pulse clear_req -> ready=0 for 16 cycles and all reads 0.
  - wr_en during the sweep -> wr_drop pulses the next cycle and data is not stored.
  - after ready, every entry reads 0.
- Reset mid-sweep at clr_cnt=7 -> ready stays low a full 16 edges after release. Also run NUM_RD=4, DATA_W=32, ADDR_W=5 (ready after 32 edges).
